dma_irq_ack_ctrl: RTL and testbench

DMA_IRQ_ACK_CTRL -- requirements
Module: dma_irq_ack_ctrl

---
 rtl/dma_irq_ack_ctrl_if.sv | 44 ++++
 rtl/dma_irq_ack_ctrl.sv | 144 ++++++++++++++
 tb/tb_dma_irq_ack_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_irq_ack_ctrl_if.sv
// ---------------------------------------------------------------------------
// dma_irq_ack_ctrl_if
// Groups the interrupt handshake, software control strobes and statistics
// of dma_irq_ack_ctrl into one bundle.
//   master : software/generator side. Drives IRQ_IN, ENABLE, ACK_REQ and
//            CLR_STATS. Observes the status word, the pending flag and the
//            statistics.
//   slave  : the controller itself (the inverse directions).
// Signal summary:
//   IRQ_IN       level interrupt from the DMA write IRQ generator
//   ENABLE       software interrupt enable
//   ACK_REQ      one-cycle pulse on a software write to the ack register
//   CLR_STATS    one-cycle pulse that clears the statistics
//   IRQ_STATUS   bit0 = registered enable, bit1 = ack in progress
//   IRQ_PENDING  interrupt waiting for software ack
//   irq_count    accepted interrupts (saturating)
//   last_latency service latency of the most recently acked interrupt
//   max_latency  largest last_latency since the last clear
//   timeout_err  sticky: generator did not drop IRQ_IN in time
// ---------------------------------------------------------------------------
interface dma_irq_ack_ctrl_if;
    logic        IRQ_IN;
    logic        ENABLE;
    logic        ACK_REQ;
    logic        CLR_STATS;
    logic [31:0] IRQ_STATUS;
    logic        IRQ_PENDING;
    logic [31:0] irq_count;
    logic [31:0] last_latency;
    logic [31:0] max_latency;
    logic        timeout_err;

    modport master (
        output IRQ_IN, ENABLE, ACK_REQ, CLR_STATS,
        input  IRQ_STATUS, IRQ_PENDING, irq_count, last_latency,
               max_latency, timeout_err
    );

    modport slave (
        input  IRQ_IN, ENABLE, ACK_REQ, CLR_STATS,
        output IRQ_STATUS, IRQ_PENDING, irq_count, last_latency,
               max_latency, timeout_err
    );
endinterface

// File: rtl/dma_irq_ack_ctrl.sv
// ---------------------------------------------------------------------------
// dma_irq_ack_ctrl
// Software acknowledge controller for a level-sensitive DMA interrupt.
// IRQ_IN is synchronised, then accepted as an interrupt while enabled. The
// controller waits for a software ack and drives the ack bit back to the
// generator until it drops IRQ_IN. If IRQ_IN does not drop within
// ACK_TIMEOUT ack cycles, the controller flags a sticky timeout error. It
// also keeps interrupt count and service latency statistics.
// Ports:
//   M_AXI_ACLK     clock, rising edge
//   M_AXI_ARESETN  asynchronous active-low reset
//   bus            dma_irq_ack_ctrl_if.slave (handshake, control, stats)
// Parameters:
//   SYNC_STAGES    synchroniser depth on IRQ_IN (2..4)
//   ACK_TIMEOUT    maximum ack cycles before flagging an error (2..65535)
// ---------------------------------------------------------------------------
module dma_irq_ack_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input logic               M_AXI_ACLK,
    input logic               M_AXI_ARESETN,
    dma_irq_ack_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2,
        ERR     = 2'd3
    } state_t;

    localparam logic [31:0] SAT_MAX   = 32'hFFFF_FFFF;
    localparam logic [15:0] ACK_LIMIT = 16'(ACK_TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   irq_s;
    state_t                 state_q;
    logic                   enable_q;
    logic [31:0]            lat_q;
    logic [15:0]            ack_tmr_q;
    logic [31:0]            irq_count_q;
    logic [31:0]            last_lat_q;
    logic [31:0]            max_lat_q;
    logic                   timeout_q;

    logic [31:0]            lat_d;
    logic [31:0]            irq_count_d;

    // Shift IRQ_IN through the synchroniser; only the last stage is used.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.IRQ_IN};
        end
    end

    assign irq_s = sync_q[SYNC_STAGES-1];

    // Saturating successors of the latency counter and the interrupt count.
    always_comb begin
        lat_d       = (lat_q == SAT_MAX) ? lat_q : lat_q + 32'd1;
        irq_count_d = (irq_count_q == SAT_MAX) ? irq_count_q : irq_count_q + 32'd1;
    end

    // Handshake FSM with statistics. The CLR_STATS assignments come last,
    // so a clear overrides any statistics update on the same edge.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            enable_q    <= 1'b0;
            lat_q       <= '0;
            ack_tmr_q   <= '0;
            irq_count_q <= '0;
            last_lat_q  <= '0;
            max_lat_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            enable_q <= bus.ENABLE;
            case (state_q)
                IDLE: begin
                    if (irq_s && bus.ENABLE) begin
                        state_q     <= PENDING;
                        lat_q       <= 32'd1;
                        irq_count_q <= irq_count_d;
                    end
                end
                PENDING: begin
                    // ENABLE is deliberately ignored here; an accepted
                    // interrupt is always waited out until software acks it.
                    if (bus.ACK_REQ) begin
                        state_q    <= ACK;
                        ack_tmr_q  <= 16'd1;
                        lat_q      <= '0;
                        last_lat_q <= lat_q;
                        if (lat_q > max_lat_q) begin
                            max_lat_q <= lat_q;
                        end
                    end else begin
                        lat_q <= lat_d;
                    end
                end
                ACK: begin
                    // A dropped IRQ_IN takes priority over the timeout, even
                    // on the cycle where the timer reaches its limit.
                    if (!irq_s) begin
                        state_q   <= IDLE;
                        ack_tmr_q <= '0;
                    end else if (ack_tmr_q == ACK_LIMIT) begin
                        state_q   <= ERR;
                        ack_tmr_q <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        ack_tmr_q <= ack_tmr_q + 16'd1;
                    end
                end
                ERR: begin
                    if (!irq_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (bus.CLR_STATS) begin
                irq_count_q <= '0;
                last_lat_q  <= '0;
                max_lat_q   <= '0;
                timeout_q   <= 1'b0;
            end
        end
    end

    assign bus.IRQ_STATUS   = {30'd0, (state_q == ACK), enable_q};
    assign bus.IRQ_PENDING  = (state_q == PENDING);
    assign bus.irq_count    = irq_count_q;
    assign bus.last_latency = last_lat_q;
    assign bus.max_latency  = max_lat_q;
    assign bus.timeout_err  = timeout_q;

endmodule

// File: tb/tb_dma_irq_ack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dma_irq_ack_ctrl
// Self-checking bench for dma_irq_ack_ctrl (SYNC_STAGES=2, ACK_TIMEOUT=16).
// It drives inputs and samples outputs on the falling clock edge. Expected
// statistics come from a small model of the counting rules: saturating
// count, last/max latency and a sticky timeout.
// ---------------------------------------------------------------------------
module tb_dma_irq_ack_ctrl;

    localparam int SYNC = 2;
    localparam int TMO  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [31:0] expCount = '0;
    logic [31:0] expLast  = '0;
    logic [31:0] expMax   = '0;
    logic        expTmo   = 1'b0;

    dma_irq_ack_ctrl_if bus ();

    dma_irq_ack_ctrl #(
        .SYNC_STAGES (SYNC),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Drive all software/generator inputs at once.
    task automatic applyStimulus(input logic irq, input logic en,
                                 input logic ack, input logic clr);
        bus.IRQ_IN    = irq;
        bus.ENABLE    = en;
        bus.ACK_REQ   = ack;
        bus.CLR_STATS = clr;
    endtask

    // Advance to the n-th following falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkStats(input string tag);
        checkOutput({tag, ".count"}, bus.irq_count, expCount);
        checkOutput({tag, ".last"},  bus.last_latency, expLast);
        checkOutput({tag, ".max"},   bus.max_latency, expMax);
        checkOutput({tag, ".tmo"},   {31'd0, bus.timeout_err}, {31'd0, expTmo});
    endtask

    // Model of the statistics rules.
    task automatic modelAccept();
        if (expCount != 32'hFFFF_FFFF) expCount = expCount + 32'd1;
    endtask

    task automatic modelAck(input int lat);
        expLast = 32'(lat);
        if (32'(lat) > expMax) expMax = 32'(lat);
    endtask

    task automatic modelClear();
        expCount = '0;
        expLast  = '0;
        expMax   = '0;
        expTmo   = 1'b0;
    endtask

    // The first PENDING cycle has just been observed. Software acks in
    // PENDING cycle 'lat'. The generator drops IRQ_IN 'dropDelay' cycles
    // into ACK. The controller must then be back in IDLE.
    task automatic ackAndDrop(input int lat, input int dropDelay, input string tag);
        tick(lat - 1);
        checkOutput({tag, ".stillPending"}, {31'd0, bus.IRQ_PENDING}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        modelAck(lat);
        checkOutput({tag, ".ackStatus"}, bus.IRQ_STATUS, 32'h3);
        checkStats({tag, ".acked"});
        tick(dropDelay);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick(SYNC + 1);
        checkOutput({tag, ".idleStatus"}, bus.IRQ_STATUS, 32'h1);
        checkOutput({tag, ".idlePending"}, {31'd0, bus.IRQ_PENDING}, 32'd0);
    endtask

    // Raise IRQ_IN from IDLE with ENABLE=1, check the pending delay, then
    // complete the handshake.
    task automatic serviceIrq(input int lat, input int dropDelay, input string tag);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick(SYNC);
        checkOutput({tag, ".notYet"}, {31'd0, bus.IRQ_PENDING}, 32'd0);
        tick(1);
        modelAccept();
        checkOutput({tag, ".pending"}, {31'd0, bus.IRQ_PENDING}, 32'd1);
        checkOutput({tag, ".count"}, bus.irq_count, expCount);
        ackAndDrop(lat, dropDelay, tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values while reset is held.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        checkOutput("rst.status", bus.IRQ_STATUS, 32'h0);
        checkOutput("rst.pending", {31'd0, bus.IRQ_PENDING}, 32'd0);
        checkStats("rst");

        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        checkOutput("en.status", bus.IRQ_STATUS, 32'h1);

        // Basic handshake with a latency of 10.
        serviceIrq(10, 0, "basic");

        // Randomized handshakes.
        for (int i = 0; i < 6; i++) begin
            serviceIrq(int'($urandom_range(1, 40)), int'($urandom_range(0, 10)), "rand");
        end

        // Clear, then two interrupts with latencies 25 and 7.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        modelClear();
        checkStats("clr1");
        serviceIrq(25, 2, "lat25");
        serviceIrq(7, 4, "lat7");
        checkOutput("two.count", bus.irq_count, 32'd2);
        checkOutput("two.max", bus.max_latency, 32'd25);

        // Ack timeout: IRQ_IN stays high through ACK.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick(SYNC + 1);
        modelAccept();
        checkOutput("tmo.pending", {31'd0, bus.IRQ_PENDING}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        modelAck(1);
        tick(TMO - 1);
        checkOutput("tmo.lastAckCycle", bus.IRQ_STATUS, 32'h3);
        checkOutput("tmo.notYetErr", {31'd0, bus.timeout_err}, 32'd0);
        tick(1);
        expTmo = 1'b1;
        checkOutput("tmo.errStatus", bus.IRQ_STATUS, 32'h1);
        checkStats("tmo.err");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick(SYNC + 1);
        checkOutput("tmo.idleStatus", bus.IRQ_STATUS, 32'h1);
        checkStats("tmo.sticky");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        modelClear();
        checkStats("clr2");

        // ENABLE low blocks acceptance; raising it accepts the held IRQ.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(100);
        checkOutput("dis.count", bus.irq_count, expCount);
        checkOutput("dis.pending", {31'd0, bus.IRQ_PENDING}, 32'd0);
        checkOutput("dis.status", bus.IRQ_STATUS, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1);
        modelAccept();
        checkOutput("ena.pending", {31'd0, bus.IRQ_PENDING}, 32'd1);
        checkOutput("ena.count", bus.irq_count, expCount);
        ackAndDrop(1, 0, "ena");

        // ACK_REQ in IDLE is ignored.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("idleAck.status", bus.IRQ_STATUS, 32'h1);
        checkOutput("idleAck.pending", {31'd0, bus.IRQ_PENDING}, 32'd0);

        // CLR_STATS and ACK_REQ on the edge entering PENDING: the clear wins
        // over the count and the ack is ignored.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick(SYNC);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        modelAccept();
        modelClear();
        checkOutput("clrEntry.pending", {31'd0, bus.IRQ_PENDING}, 32'd1);
        checkOutput("clrEntry.status", bus.IRQ_STATUS, 32'h1);
        checkStats("clrEntry");
        ackAndDrop(int'($urandom_range(2, 30)), 1, "clrEntry");

        // Reset in the middle of ACK with IRQ_IN still high.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick(SYNC + 1);
        modelAccept();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        modelAck(1);
        checkOutput("preRst.status", bus.IRQ_STATUS, 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        modelClear();
        checkOutput("asyncRst.status", bus.IRQ_STATUS, 32'h0);
        checkOutput("asyncRst.pending", {31'd0, bus.IRQ_PENDING}, 32'd0);
        checkStats("asyncRst");
        @(negedge clk);
        rst_n = 1'b1;
        tick(SYNC);
        checkOutput("reacc.notYet", {31'd0, bus.IRQ_PENDING}, 32'd0);
        tick(1);
        modelAccept();
        checkOutput("reacc.pending", {31'd0, bus.IRQ_PENDING}, 32'd1);
        checkOutput("reacc.count", bus.irq_count, 32'd1);
        ackAndDrop(3, 0, "reacc");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
